// File: rtl/vga_pkg.sv
// Shared definitions for the video-memory bus arbiter and its users.
// Holds the arbiter state encoding, Wishbone widths and the default burst /
// outstanding limits that the video master logic is also built against.
package vga_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;

  localparam int unsigned M0_BURST_MAX_DEF = 16;
  localparam int unsigned M1_BURST_MAX_DEF = 4;
  localparam int unsigned MAX_OUT_DEF      = 8;

  // Burst counter saturates, so a lone requester can stream forever.
  localparam int unsigned BURST_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT0 = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_DRAIN0 = 3'd3,
    ST_DRAIN1 = 3'd4
  } arb_state_t;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle.
// master drives cyc/stb/we/adr/sel/dat_m; slave drives ack/stall/dat_s.
interface if_wb;
  import vga_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [WB_AW-1:0] adr;
  logic [WB_SW-1:0] sel;
  logic [WB_DW-1:0] dat_m;
  logic             ack;
  logic             stall;
  logic [WB_DW-1:0] dat_s;

  modport master (output cyc, stb, we, adr, sel, dat_m,
                  input  ack, stall, dat_s);
  modport slave  (input  cyc, stb, we, adr, sel, dat_m,
                  output ack, stall, dat_s);
endinterface

// File: rtl/wb_outstanding_ctr.sv
// Accepted-but-unacked transfer counter for the shared bus.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   inc_i         accepted strobe this cycle
//   dec_i         ack seen on the bus this cycle
//   count_o       current outstanding count
//   full_o        count == MAX_OUT
//   empty_o       count == 0
//   spurious_o    ack arrived with nothing outstanding (ignored for counting)
module wb_outstanding_ctr #(
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned W       = $clog2(MAX_OUT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         spurious_o
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = W'(MAX_OUT);

  logic [W-1:0] count_q, count_d;
  logic         inc_ok, dec_ok;

  assign full_o     = (count_q == CNT_MAX);
  assign empty_o    = (count_q == '0);
  assign inc_ok     = inc_i & ~full_o;
  assign dec_ok     = dec_i & ~empty_o;
  assign spurious_o = dec_i & empty_o;
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_ok && !dec_ok)      count_d = count_q + CNT_ONE;
    else if (dec_ok && !inc_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/vga_bus_arbiter.sv
// Two-way arbiter for the single video-memory Wishbone port.
// m0 (scanout) has priority, m1 (CPU/blitter) is the secondary requester.
// Ownership only changes once the bus has no outstanding transfers, and each
// side yields after its burst limit when the other side is waiting.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   m0            scanout requester (slave side)
//   m1            CPU/blitter requester (slave side)
//   outbus        shared video-memory bus (master side)
//   err_o         sticky: ack received with no transfer outstanding
module vga_bus_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned M0_BURST_MAX = M0_BURST_MAX_DEF,
  parameter int unsigned M1_BURST_MAX = M1_BURST_MAX_DEF,
  parameter int unsigned MAX_OUT      = MAX_OUT_DEF
) (
  input  logic  clk_i,
  input  logic  rst_i,
  if_wb.slave   m0,
  if_wb.slave   m1,
  if_wb.master  outbus,
  output logic  err_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [BURST_CNT_W-1:0] BURST_ONE = BURST_CNT_W'(1);
  localparam logic [BURST_CNT_W-1:0] BURST_SAT = '1;
  localparam logic [BURST_CNT_W-1:0] M0_LIM    = BURST_CNT_W'(M0_BURST_MAX);
  localparam logic [BURST_CNT_W-1:0] M1_LIM    = BURST_CNT_W'(M1_BURST_MAX);

  arb_state_t             state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d, burst_next;
  logic                   err_q, err_d;

  logic [OUT_W-1:0] outstanding;
  logic             full, empty, spurious;
  logic             accept, ack_fwd, own0, own1;

  assign accept  = outbus.stb & ~outbus.stall;
  // Acks with nothing outstanding are dropped here rather than forwarded.
  assign ack_fwd = outbus.ack & ~empty;
  assign own0    = (state_q == ST_GRANT0) || (state_q == ST_DRAIN0);
  assign own1    = (state_q == ST_GRANT1) || (state_q == ST_DRAIN1);

  wb_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (accept),
    .dec_i      (outbus.ack),
    .count_o    (outstanding),
    .full_o     (full),
    .empty_o    (empty),
    .spurious_o (spurious)
  );

  always_comb begin
    outbus.cyc   = 1'b0;
    outbus.stb   = 1'b0;
    outbus.we    = 1'b0;
    outbus.adr   = '0;
    outbus.sel   = '0;
    outbus.dat_m = '0;
    m0.stall     = 1'b1;
    m1.stall     = 1'b1;
    m0.ack       = own0 & ack_fwd;
    m1.ack       = own1 & ack_fwd;
    m0.dat_s     = outbus.dat_s;
    m1.dat_s     = outbus.dat_s;
    unique case (state_q)
      ST_GRANT0: begin
        // cyc held while acks are still due, even if m0 dropped it early
        outbus.cyc   = m0.cyc | ~empty;
        outbus.stb   = m0.cyc & m0.stb & ~full;
        outbus.we    = m0.we;
        outbus.adr   = m0.adr;
        outbus.sel   = m0.sel;
        outbus.dat_m = m0.dat_m;
        m0.stall     = outbus.stall | full;
      end
      ST_GRANT1: begin
        outbus.cyc   = m1.cyc | ~empty;
        outbus.stb   = m1.cyc & m1.stb & ~full;
        outbus.we    = m1.we;
        outbus.adr   = m1.adr;
        outbus.sel   = m1.sel;
        outbus.dat_m = m1.dat_m;
        m1.stall     = outbus.stall | full;
      end
      ST_DRAIN0, ST_DRAIN1: outbus.cyc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    burst_next = burst_cnt_q;
    if (accept && (burst_cnt_q != BURST_SAT)) burst_next = burst_cnt_q + BURST_ONE;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0.cyc)      state_d = ST_GRANT0;
        else if (m1.cyc) state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (!m0.cyc) begin
          if (empty) state_d = ST_IDLE;
        end else if (m1.cyc && (burst_next >= M0_LIM)) begin
          // counting this cycle's strobe yields after exactly M0_BURST_MAX
          state_d = ST_DRAIN0;
        end
      end
      ST_GRANT1: begin
        if (!m1.cyc) begin
          if (empty) state_d = ST_IDLE;
        end else if (m0.cyc && (burst_next >= M1_LIM)) begin
          state_d = ST_DRAIN1;
        end
      end
      ST_DRAIN0: if (empty) state_d = ST_GRANT1;
      ST_DRAIN1: if (empty) state_d = ST_GRANT0;
      default:   state_d = ST_IDLE;
    endcase
    burst_cnt_d = (state_d != state_q) ? '0 : burst_next;
    err_d       = err_q | spurious;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
module tb_vga_bus_arbiter;
  import vga_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic err_o;

  always #5 clk_i = ~clk_i;

  if_wb m0_if ();
  if_wb m1_if ();
  if_wb out_if ();

  vga_bus_arbiter dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .m0     (m0_if),
    .m1     (m1_if),
    .outbus (out_if),
    .err_o  (err_o)
  );

  typedef struct {
    logic [31:0] adr;
    int          ready;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;
  bit mem_en = 1, one_ack = 0, spur_ack = 0, mem_stall = 0;
  bit acc0, acc1, acc_out, ack_out_s, cyc_out_s, stall1_s, m1_stall_low;
  int ack0_n, ack1_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Sample the cycle, advance one clock, then drive the memory side.
  task automatic step();
    mem_req_t r;
    #1;
    acc0      = m0_if.cyc && m0_if.stb && !m0_if.stall;
    acc1      = m1_if.cyc && m1_if.stb && !m1_if.stall;
    acc_out   = out_if.stb && !out_if.stall;
    ack_out_s = out_if.ack;
    cyc_out_s = out_if.cyc;
    stall1_s  = m1_if.stall;
    if (!m1_if.stall) m1_stall_low = 1;
    if (exp_q0.size() == 0) check("m0_unexpected_ack", m0_if.ack, 0);
    else if (m0_if.ack) begin
      ack0_n++;
      check("m0_dat_s", m0_if.dat_s, exp_q0.pop_front());
    end
    if (exp_q1.size() == 0) check("m1_unexpected_ack", m1_if.ack, 0);
    else if (m1_if.ack) begin
      ack1_n++;
      check("m1_dat_s", m1_if.dat_s, exp_q1.pop_front());
    end
    if (acc0) exp_q0.push_back(mem_data(m0_if.adr));
    if (acc1) exp_q1.push_back(mem_data(m1_if.adr));
    if (acc_out) mem_q.push_back('{adr: out_if.adr, ready: cyc_n + 2});
    @(posedge clk_i);
    #1;
    cyc_n++;
    out_if.ack   = 1'b0;
    out_if.dat_s = '0;
    if (spur_ack) begin
      out_if.ack = 1'b1;
      spur_ack   = 0;
    end else if (mem_q.size() > 0 && mem_q[0].ready <= cyc_n && (mem_en || one_ack)) begin
      r = mem_q.pop_front();
      out_if.ack   = 1'b1;
      out_if.dat_s = mem_data(r.adr);
      one_ack      = 0;
    end
    out_if.stall = mem_stall;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check(tag, (n < 200), 1);
  endtask

  task automatic accept_m0(input int want, input string tag);
    int cnt = 0;
    int n = 0;
    while (cnt < want && n < 100) begin
      step();
      n++;
      if (acc0) begin
        cnt++;
        m0_if.adr = m0_if.adr + 32'd4;
      end
    end
    m0_if.stb = 1'b0;
    check(tag, cnt, want);
  endtask

  task automatic accept_m1(input int want, input string tag);
    int cnt = 0;
    int n = 0;
    while (cnt < want && n < 100) begin
      step();
      n++;
      if (acc1) begin
        cnt++;
        m1_if.adr = m1_if.adr + 32'd4;
      end
    end
    m1_if.stb = 1'b0;
    check(tag, cnt, want);
  endtask

  int run_owner[4];
  int run_len[4];

  initial begin
    int nruns, gaps, cnt, owner;
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = '0; m0_if.sel = 4'hF; m0_if.dat_m = '0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 1; m1_if.adr = '0; m1_if.sel = 4'h3; m1_if.dat_m = 32'h1234;
    out_if.ack = 0; out_if.stall = 0; out_if.dat_s = '0;

    // reset state
    #2;
    check("rst_out_cyc", out_if.cyc, 0);
    check("rst_out_stb", out_if.stb, 0);
    check("rst_out_adr", out_if.adr, 0);
    check("rst_m0_stall", m0_if.stall, 1);
    check("rst_m1_stall", m1_if.stall, 1);
    check("rst_m0_ack", m0_if.ack, 0);
    check("rst_err", err_o, 0);
    step();
    rst_i = 1'b0;
    step();

    // m0 alone, 8 pipelined reads
    m1_stall_low = 0; ack0_n = 0;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100;
    accept_m0(8, "s1_accepts");
    wait_drained("s1_drain");
    check("s1_acks", ack0_n, 8);
    check("s1_m1_stall_held", m1_stall_low, 0);
    check("s1_outstanding", dut.outstanding, 0);
    m0_if.cyc = 0;
    step();
    #1;
    check("s1_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("s1_out_cyc", out_if.cyc, 0);

    // both requesters streaming: alternating bursts 16 / 4
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h1000;
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h8000;
    nruns = 0; gaps = 0; cnt = 0;
    while (nruns < 4 && cnt < 600) begin
      step();
      cnt++;
      if (nruns > 0 && !cyc_out_s) gaps++;
      if (acc0 || acc1) begin
        owner = acc1 ? 1 : 0;
        if (nruns == 0 || run_owner[nruns-1] != owner) begin
          run_owner[nruns] = owner;
          run_len[nruns] = 0;
          nruns++;
        end
        run_len[nruns-1]++;
        if (acc0) m0_if.adr = m0_if.adr + 32'd4;
        if (acc1) m1_if.adr = m1_if.adr + 32'd4;
      end
    end
    check("s2_runs", nruns, 4);
    check("s2_first_owner", run_owner[0], 0);
    check("s2_m0_burst", run_len[0], 16);
    check("s2_second_owner", run_owner[1], 1);
    check("s2_m1_burst", run_len[1], 4);
    check("s2_third_owner", run_owner[2], 0);
    check("s2_m0_burst2", run_len[2], 16);
    check("s2_fourth_owner", run_owner[3], 1);
    check("s2_cyc_gaps", gaps, 0);
    m0_if.stb = 0; m1_if.stb = 0;
    wait_drained("s2_drain");
    m0_if.cyc = 0; m1_if.cyc = 0;
    step(); step();
    #1;
    check("s2_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // bus stall in GRANT1
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h4000;
    accept_m1(2, "s3_pre_accepts");
    wait_drained("s3_pre_drain");
    mem_stall = 1;
    step();
    m1_if.stb = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s3_no_accept", acc_out, 0);
      check("s3_m1_stall", stall1_s, 1);
      check("s3_adr_held", out_if.adr, 32'h4008);
    end
    check("s3_burst_cnt", dut.burst_cnt_q, 2);
    check("s3_outstanding", dut.outstanding, 0);
    mem_stall = 0;
    accept_m1(1, "s3_post_accept");
    wait_drained("s3_drain");
    m1_if.cyc = 0;
    step(); step();

    // memory never acks: outstanding limit
    mem_en = 0;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h200;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (acc0) begin
        cnt++;
        m0_if.adr = m0_if.adr + 32'd4;
      end
    end
    check("s4_accepts_at_limit", cnt, 8);
    #1;
    check("s4_m0_stall_full", m0_if.stall, 1);
    check("s4_out_stb_full", out_if.stb, 0);
    one_ack = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (acc0) begin
        cnt++;
        m0_if.adr = m0_if.adr + 32'd4;
      end
    end
    check("s4_one_more", cnt, 1);
    m0_if.stb = 0;
    mem_en = 1;
    wait_drained("s4_drain");

    // accept and ack in the same cycle at outstanding 3
    mem_en = 0;
    m0_if.stb = 1;
    accept_m0(3, "s5_accepts");
    step(); step(); step();
    #1;
    check("s5_outstanding_pre", dut.outstanding, 3);
    one_ack = 1;
    step();
    m0_if.stb = 1;
    step();
    m0_if.adr = m0_if.adr + 32'd4;
    m0_if.stb = 0;
    check("s5_accept", acc_out, 1);
    check("s5_ack", ack_out_s, 1);
    #1;
    check("s5_outstanding_post", dut.outstanding, 3);
    mem_en = 1;
    wait_drained("s5_drain");
    m0_if.cyc = 0;
    step(); step();

    // spurious ack in IDLE
    spur_ack = 1;
    step();
    step();
    #1;
    check("s5_spur_err", err_o, 1);

    // reset mid-GRANT1 with 4 outstanding
    mem_en = 0;
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h6000;
    accept_m1(4, "s6_accepts");
    #1;
    check("s6_outstanding_pre", dut.outstanding, 4);
    check("s6_grant1", 32'(dut.state_q), 32'(ST_GRANT1));
    rst_i = 1'b1;
    m1_if.cyc = 0;
    #1;
    check("s6_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("s6_rst_outstanding", dut.outstanding, 0);
    check("s6_rst_out_cyc", out_if.cyc, 0);
    step();
    rst_i = 1'b0;
    #1;
    check("s6_err_cleared", err_o, 0);
    exp_q1.delete();
    ack1_n = 0;
    mem_en = 1;
    for (int i = 0; i < 8; i++) step();
    #1;
    check("s6_stray_err", err_o, 1);
    check("s6_no_fwd_ack", ack1_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
